// File: rtl/rpm_gate_sequencer_if.sv
// Signal bundle between the tach front end and the data-gathering/phone link:
// measurement control and tach line in, published speed and flags out.
interface rpm_gate_sequencer_if;
   logic        enable;
   logic        blips;
   logic [15:0] rpm;
   logic [7:0]  rpm_phone;
   logic        rpm_valid;
   logic        rpm_zero;
   logic        edge_sat;

   modport master (output enable, blips,
                   input  rpm, rpm_phone, rpm_valid, rpm_zero, edge_sat);
   modport slave  (input  enable, blips,
                   output rpm, rpm_phone, rpm_valid, rpm_zero, edge_sat);
endinterface

// File: rtl/rpm_gate_sequencer.sv
// Motor speed gate: counts synchronized blips rising edges per gate window and
// divides to RPM. Define RPM_AVG_EN to publish the mean of this and the previous result.
module rpm_gate_sequencer #(
   parameter int CLK_HZ      = 50_000_000,
   parameter int GATE_CYCLES = CLK_HZ,
   parameter int POLES       = 16,
   parameter int GEAR_RATIO  = 5
) (
   input  logic                 clk50M,
   input  logic                 reset,
   rpm_gate_sequencer_if.slave  bus
);
   localparam int              WIN_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(GATE_CYCLES - 1);
   localparam logic [22:0]     DIVISOR  = 23'(POLES * GEAR_RATIO);
   localparam logic [4:0]      DIV_LAST = 5'd21;

   typedef enum logic [2:0] {S_COUNT, S_LATCH, S_DIVIDE, S_AVG, S_PUBLISH} state_t;

   state_t           state;
   logic [2:0]       sync;
   logic             rise;
   logic [WIN_W-1:0] win_cnt;
   logic [15:0]      edge_cnt;
   logic [15:0]      edge_next;
   logic             edge_full;
   logic             sat_next;
   logic             term;

   logic [15:0]      op_cnt;
   logic             op_zero;
   logic             op_sat;
   logic [21:0]      num;
   logic [21:0]      rem;
   logic [4:0]       bit_cnt;
   logic [22:0]      shifted;
   logic             q_bit;
   logic [21:0]      rem_nxt;
   logic [21:0]      quo_nxt;
   logic [15:0]      raw_sat;

   logic [15:0]      rpm_q;
   logic [7:0]       phone_q;
   logic             valid_q;
   logic             zero_q;
   logic             sat_q;

   function automatic logic [7:0] phone_of(input logic [15:0] r);
      return (r[15:9] != 7'd0) ? 8'hFF : r[8:1];
   endfunction

   // sync[1:0] is the synchronizer, sync[2] the previous synchronized level.
   assign rise      = sync[1] & ~sync[2];
   assign edge_full = (edge_cnt == 16'hFFFF);
   assign edge_next = (edge_full || !rise) ? edge_cnt : edge_cnt + 16'd1;
   assign sat_next  = edge_full | (edge_next == 16'hFFFF);
   assign term      = bus.enable && (win_cnt == WIN_LAST);

   logic edge_sat_flag;

   always_ff @(posedge clk50M or posedge reset) begin
      if (reset) begin
         sync          <= '0;
         win_cnt       <= '0;
         edge_cnt      <= '0;
         edge_sat_flag <= 1'b0;
      end else begin
         sync <= {sync[1:0], bus.blips};
         if (!bus.enable || term) begin
            win_cnt       <= '0;
            edge_cnt      <= '0;
            edge_sat_flag <= 1'b0;
         end else begin
            win_cnt       <= win_cnt + WIN_W'(1);
            edge_cnt      <= edge_next;
            edge_sat_flag <= edge_sat_flag | sat_next;
         end
      end
   end

   // Restoring divider: num shifts out the dividend and fills with quotient bits.
   assign shifted = {rem, num[21]};
   assign q_bit   = (shifted >= DIVISOR);
   assign rem_nxt = q_bit ? 22'(shifted - DIVISOR) : shifted[21:0];
   assign quo_nxt = {num[20:0], q_bit};
   assign raw_sat = (quo_nxt > 22'h00FFFF) ? 16'hFFFF : quo_nxt[15:0];

`ifdef RPM_AVG_EN
   logic [15:0] raw_q;
   logic [15:0] prev_q;
   logic        have_prev;
   logic        en_d;
   logic [16:0] avg_sum;
   logic [15:0] avg_rpm;

   assign avg_sum = {1'b0, raw_q} + {1'b0, prev_q} + 17'd1;
   assign avg_rpm = have_prev ? 16'(avg_sum >> 1) : raw_q;
`endif

   always_ff @(posedge clk50M or posedge reset) begin
      if (reset) begin
         state   <= S_COUNT;
         op_cnt  <= '0;
         op_zero <= 1'b1;
         op_sat  <= 1'b0;
         num     <= '0;
         rem     <= '0;
         bit_cnt <= '0;
         rpm_q   <= '0;
         phone_q <= '0;
         valid_q <= 1'b0;
         zero_q  <= 1'b1;
         sat_q   <= 1'b0;
`ifdef RPM_AVG_EN
         raw_q     <= '0;
         prev_q    <= '0;
         have_prev <= 1'b0;
         en_d      <= 1'b0;
`endif
      end else begin
         valid_q <= 1'b0;
         case (state)
            S_COUNT: begin
               // Capture includes an edge detected in the terminal cycle itself.
               if (term) begin
                  op_cnt  <= edge_next;
                  op_zero <= (edge_next == 16'd0);
                  op_sat  <= edge_sat_flag | sat_next;
                  state   <= S_LATCH;
               end
            end
            S_LATCH: begin
               num     <= 22'(op_cnt) * 22'd60;
               rem     <= '0;
               bit_cnt <= '0;
               state   <= S_DIVIDE;
            end
            S_DIVIDE: begin
               num     <= quo_nxt;
               rem     <= rem_nxt;
               bit_cnt <= bit_cnt + 5'd1;
               if (bit_cnt == DIV_LAST) begin
`ifdef RPM_AVG_EN
                  raw_q <= raw_sat;
                  state <= S_AVG;
`else
                  rpm_q   <= raw_sat;
                  phone_q <= phone_of(raw_sat);
                  zero_q  <= op_zero;
                  sat_q   <= op_sat;
                  valid_q <= 1'b1;
                  state   <= S_PUBLISH;
`endif
               end
            end
`ifdef RPM_AVG_EN
            S_AVG: begin
               rpm_q     <= avg_rpm;
               phone_q   <= phone_of(avg_rpm);
               zero_q    <= op_zero;
               sat_q     <= op_sat;
               prev_q    <= raw_q;
               have_prev <= 1'b1;
               valid_q   <= 1'b1;
               state     <= S_PUBLISH;
            end
`endif
            S_PUBLISH: state <= S_COUNT;
            default:   state <= S_COUNT;
         endcase
`ifdef RPM_AVG_EN
         // A fresh measurement run must not be blended with stale history.
         en_d <= bus.enable;
         if (bus.enable && !en_d) have_prev <= 1'b0;
`endif
      end
   end

   assign bus.rpm       = rpm_q;
   assign bus.rpm_phone = phone_q;
   assign bus.rpm_valid = valid_q;
   assign bus.rpm_zero  = zero_q;
   assign bus.edge_sat  = sat_q;

endmodule
